// File: rtl/jk_cmd_driver_if.sv
// rtl/jk_cmd_driver_if.sv - command handshake bundle between a command source and jk_cmd_driver
interface jk_cmd_driver_if #(
    parameter int CNT_W = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_cnt,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_cnt,
        output cmd_ready
    );
endinterface

// File: rtl/jk_cmd_driver.sv
// rtl/jk_cmd_driver.sv - buffered hold/reset/set/toggle sequencer for a JK flop with q reference check
module jk_cmd_driver #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    jk_cmd_driver_if.slave           cmd,
    output logic                     j,
    output logic                     k,
    input  logic                     q_in,
    input  logic                     qb_in,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     exp_valid,
    output logic                     exp_q,
    output logic                     mismatch
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_DRIVE} state_t;

    logic [CNT_W+1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [AW:0]      count;
    logic             full, empty, push, pop;
    logic [1:0]       head_op;
    logic [CNT_W-1:0] head_cnt;

    state_t           state, state_n;
    logic [CNT_W-1:0] rem, rem_n;
    logic             j_n, k_n;

    assign full          = (count == FULL_LVL);
    assign empty         = (count == '0);
    assign cmd.cmd_ready = !full;
    assign push          = cmd.cmd_valid && !full;
    assign head_op       = mem[rd_ptr][CNT_W+1:CNT_W];
    assign head_cnt      = mem[rd_ptr][CNT_W-1:0];
    assign level         = count;
    assign busy          = (state == S_DRIVE) || !empty;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {cmd.cmd_op, cmd.cmd_cnt};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
            rem   <= '0;
            j     <= 1'b0;
            k     <= 1'b0;
        end else begin
            state <= state_n;
            rem   <= rem_n;
            j     <= j_n;
            k     <= k_n;
        end
    end

    always_comb begin
        state_n = state;
        rem_n   = rem;
        j_n     = j;
        k_n     = k;
        pop     = 1'b0;
        if (state == S_DRIVE && rem > CNT_W'(1)) begin
            rem_n = rem - CNT_W'(1);
        end else begin
            // Idle, or the last drive cycle: fetch the next entry with no gap.
            state_n = S_IDLE;
            j_n     = 1'b0;
            k_n     = 1'b0;
            if (!empty) begin
                pop = 1'b1;
                if (head_cnt != '0) begin
                    state_n    = S_DRIVE;
                    rem_n      = head_cnt;
                    {j_n, k_n} = head_op;
                end
            end
        end
    end

    // Model advances on the same edge the flop samples j/k, so exp_q lines up with q_in.
    always_ff @(posedge clock) begin
        if (!reset) begin
            exp_valid <= 1'b0;
            exp_q     <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            if (exp_valid && ((q_in != exp_q) || (qb_in != !exp_q))) begin
                mismatch <= 1'b1;
            end
            case ({j, k})
                2'b01: begin
                    exp_q     <= 1'b0;
                    exp_valid <= 1'b1;
                end
                2'b10: begin
                    exp_q     <= 1'b1;
                    exp_valid <= 1'b1;
                end
                2'b11: begin
                    if (exp_valid) exp_q <= !exp_q;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb/tb_jk_cmd_driver.sv - scoreboard bench for jk_cmd_driver driving a behavioural JK flop
module tb_jk_cmd_driver;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    jk_cmd_driver_if #(.CNT_W(CNT_W)) cif ();

    logic       j, k, q_in, qb_in, busy, exp_valid, exp_q, mismatch;
    logic [2:0] level;
    logic       fq = 1'b0;
    logic       inject = 1'b0;

    jk_cmd_driver #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd       (cif),
        .j         (j),
        .k         (k),
        .q_in      (q_in),
        .qb_in     (qb_in),
        .busy      (busy),
        .level     (level),
        .exp_valid (exp_valid),
        .exp_q     (exp_q),
        .mismatch  (mismatch)
    );

    // Downstream JK flop; inject corrupts the returned q only.
    always @(posedge clock) begin
        if (!reset) fq <= 1'b0;
        else begin
            case ({j, k})
                2'b01:   fq <= 1'b0;
                2'b10:   fq <= 1'b1;
                2'b11:   fq <= ~fq;
                default: fq <= fq;
            endcase
        end
    end
    assign q_in  = inject ? ~fq : fq;
    assign qb_in = ~fq;

    int n_checks = 0;
    int n_fail   = 0;
    logic [1:0] sb_q [$];

    logic [1:0] t2_jk [6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00};
    logic       t2_eq [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clock) begin
        if (reset && (j || k)) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: got jk=%b expected no activity", {j, k});
            end else begin
                chk("sb_jk", int'({j, k}), int'(sb_q.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cif.cmd_valid = 1'b0;
        sb_q.delete();
        step(2);
        reset = 1'b1;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] cnt);
        int t;
        t = 0;
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = op;
        cif.cmd_cnt   = cnt;
        while (!cif.cmd_ready && t < 100) begin
            step(1);
            t++;
        end
        if (t == 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: got ready=0 after %0d cycles expected ready", t);
        end
        for (int i = 0; i < int'(cnt); i++) sb_q.push_back(op);
        step(1);
        cif.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (busy && t < 300) begin
            step(1);
            t++;
        end
        if (t == 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: got busy=1 after %0d cycles expected 0", t);
        end
        step(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"},     int'(cif.cmd_ready), 1);
        chk({tag, "_level"},     int'(level), 0);
        chk({tag, "_busy"},      int'(busy), 0);
        chk({tag, "_jk"},        int'({j, k}), 0);
        chk({tag, "_exp_valid"}, int'(exp_valid), 0);
        chk({tag, "_exp_q"},     int'(exp_q), 0);
        chk({tag, "_mismatch"},  int'(mismatch), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cif.cmd_valid = 1'b0;
        cif.cmd_op    = 2'b00;
        cif.cmd_cnt   = '0;
        #1;

        // Reset, then a single set command with latency checks.
        do_reset();
        chk_reset_vals("rst");
        push(2'b10, 4'd3);
        chk("lat_n_jk", int'({j, k}), 0);
        chk("lat_n_level", int'(level), 1);
        step(1);
        chk("lat_n1_jk", int'({j, k}), 2);
        chk("lat_n1_level", int'(level), 0);
        wait_idle();
        chk("set_exp_valid", int'(exp_valid), 1);
        chk("set_exp_q", int'(exp_q), 1);
        chk("set_q_in", int'(q_in), 1);
        chk("set_mismatch", int'(mismatch), 0);

        // Back-to-back set then toggle with no gap.
        push(2'b10, 4'd1);
        push(2'b11, 4'd4);
        for (int i = 0; i < 6; i++) begin
            chk("b2b_jk", int'({j, k}), int'(t2_jk[i]));
            chk("b2b_exp_q", int'(exp_q), int'(t2_eq[i]));
            chk("b2b_q_in", int'(q_in), int'(t2_eq[i]));
            step(1);
        end
        chk("b2b_mismatch", int'(mismatch), 0);

        // Toggle before the model is known: no check, whatever q_in does.
        do_reset();
        inject = 1'b1;
        push(2'b11, 4'd2);
        wait_idle();
        inject = 1'b0;
        chk("tog_exp_valid", int'(exp_valid), 0);
        chk("tog_mismatch", int'(mismatch), 0);

        // Fill the FIFO behind a long reset command; overflow pushes refused.
        push(2'b01, 4'd15);
        push(2'b10, 4'd2);
        push(2'b11, 4'd1);
        push(2'b01, 4'd3);
        push(2'b10, 4'd1);
        chk("full_level", int'(level), 4);
        chk("full_ready", int'(cif.cmd_ready), 0);
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b11;
        cif.cmd_cnt   = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("ovf_ready", int'(cif.cmd_ready), 0);
            chk("ovf_level", int'(level), 4);
        end
        cif.cmd_valid = 1'b0;
        wait_idle();
        chk("drain_level", int'(level), 0);
        chk("drain_exp_q", int'(exp_q), 1);
        chk("drain_mismatch", int'(mismatch), 0);

        // Zero-count entry is dropped for one idle cycle.
        push(2'b10, 4'd0);
        push(2'b01, 4'd2);
        chk("drop_jk", int'({j, k}), 0);
        chk("drop_busy", int'(busy), 1);
        chk("drop_level", int'(level), 1);
        step(1);
        chk("drop_next_jk0", int'({j, k}), 1);
        step(1);
        chk("drop_next_jk1", int'({j, k}), 1);
        step(1);
        chk("drop_end_jk", int'({j, k}), 0);
        wait_idle();
        chk("drop_exp_q", int'(exp_q), 0);

        // Forced q error after a set latches mismatch.
        push(2'b10, 4'd2);
        wait_idle();
        chk("err_pre_exp_q", int'(exp_q), 1);
        chk("err_pre_mismatch", int'(mismatch), 0);
        inject = 1'b1;
        step(1);
        inject = 1'b0;
        chk("err_mismatch", int'(mismatch), 1);
        step(3);
        chk("err_sticky", int'(mismatch), 1);

        // Reset in the middle of a command, with cmd_valid held during reset.
        push(2'b11, 4'd8);
        push(2'b10, 4'd4);
        step(2);
        reset = 1'b0;
        sb_q.delete();
        cif.cmd_valid = 1'b1;
        cif.cmd_op    = 2'b10;
        cif.cmd_cnt   = 4'd3;
        step(1);
        chk_reset_vals("mid_rst");
        step(1);
        chk("mid_rst_hold_level", int'(level), 0);
        cif.cmd_valid = 1'b0;
        reset = 1'b1;
        step(3);
        chk("post_rst_jk", int'({j, k}), 0);
        chk("post_rst_level", int'(level), 0);
        chk("post_rst_busy", int'(busy), 0);

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
